// File: rtl/bcd_serial_comparator.sv
// bcd_serial_comparator
//   Sequential BCD magnitude comparator for DIGITS-digit operands. One digit
//   pair is examined per clock, starting at the most significant digit. An
//   accepted request latches a, b and mode. The scan ends with a one-cycle done
//   pulse and held GT/EQ/LT/invalid flags plus a mode-selected result bit.
//   With EARLY_EXIT=1 the scan stops at the first unequal digit pair. With
//   EARLY_EXIT=0 it always runs DIGITS cycles. A non-BCD digit always ends the
//   scan immediately.
// Ports
//   clk, rst_n        clock, async active-low reset
//   start             request, accepted in IDLE or DONE
//   a, b [4*DIGITS]   BCD operands, MSD in the top nibble
//   mode [2]          00 A>=B, 01 A>B, 10 A==B, 11 A<B
//   busy              scanning
//   done              one-cycle pulse, result and flags valid
//   result            mode-selected comparison (0 when invalid)
//   a_gt_b/a_eq_b/a_lt_b/invalid   held flags, cleared on accept

// Compares one digit pair and flags any nibble that is not a BCD digit.
module bcd_digit_cmp (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic       gt_o,
  output logic       lt_o,
  output logic       bad_o
);
  assign gt_o  = a_i > b_i;
  assign lt_o  = a_i < b_i;
  assign bad_o = (a_i > 4'd9) || (b_i > 4'd9);
endmodule

module bcd_serial_comparator #(
  parameter int DIGITS     = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic [1:0]            mode,
  output logic                  busy,
  output logic                  done,
  output logic                  result,
  output logic                  a_gt_b,
  output logic                  a_eq_b,
  output logic                  a_lt_b,
  output logic                  invalid
);
  localparam int W  = 4*DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [1:0]    mode_q, mode_d;
  logic [IW-1:0] idx_q, idx_d;
  // First difference seen so far. This is only used when the scan always runs
  // to the last digit.
  logic          dgt_q, dgt_d, dlt_q, dlt_d;
  logic          gt_q, gt_d, eq_q, eq_d, lt_q, lt_d, inv_q, inv_d, res_q, res_d;

  logic [DIGITS-1:0] dg_gt, dg_lt, dg_bad;
  logic cur_gt, cur_lt, cur_bad, last, decide, accept;
  logic fin_gt, fin_lt;

  // Compare all digit pairs in parallel, then select the one at the scan index.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit_cmp u_cmp (
      .a_i  (a_q[4*g +: 4]),
      .b_i  (b_q[4*g +: 4]),
      .gt_o (dg_gt[g]),
      .lt_o (dg_lt[g]),
      .bad_o(dg_bad[g])
    );
  end

  assign cur_gt  = dg_gt[idx_q];
  assign cur_lt  = dg_lt[idx_q];
  assign cur_bad = dg_bad[idx_q];
  assign last    = (idx_q == '0);
  assign accept  = start && (state_q != S_SCAN);
  assign decide  = (state_q == S_SCAN) &&
                   (cur_bad || last || ((EARLY_EXIT != 0) && (cur_gt || cur_lt)));

  // The final ordering comes from the first difference seen. When early exit is
  // enabled, that difference is always the current digit pair.
  always_comb begin
    if (EARLY_EXIT != 0) begin
      fin_gt = cur_gt;
      fin_lt = cur_lt;
    end else begin
      fin_gt = dgt_q || (!dlt_q && cur_gt);
      fin_lt = dlt_q || (!dgt_q && cur_lt);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SCAN;
      S_SCAN:  if (decide) state_d = S_DONE;
      S_DONE:  state_d = start ? S_SCAN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == S_SCAN);
    done = (state_q == S_DONE);
  end

  // Datapath next state
  always_comb begin
    a_d = a_q; b_d = b_q; mode_d = mode_q; idx_d = idx_q;
    dgt_d = dgt_q; dlt_d = dlt_q;
    gt_d = gt_q; eq_d = eq_q; lt_d = lt_q; inv_d = inv_q; res_d = res_q;
    if (accept) begin
      a_d = a; b_d = b; mode_d = mode;
      idx_d = IW'(DIGITS-1);
      dgt_d = 1'b0; dlt_d = 1'b0;
      gt_d = 1'b0; eq_d = 1'b0; lt_d = 1'b0; inv_d = 1'b0; res_d = 1'b0;
    end else if (state_q == S_SCAN) begin
      if (decide) begin
        if (cur_bad) begin
          inv_d = 1'b1;
        end else begin
          gt_d = fin_gt;
          lt_d = fin_lt;
          eq_d = !fin_gt && !fin_lt;
          case (mode_q)
            2'b00:   res_d = fin_gt || !fin_lt;
            2'b01:   res_d = fin_gt;
            2'b10:   res_d = !fin_gt && !fin_lt;
            default: res_d = fin_lt;
          endcase
        end
      end else begin
        idx_d = idx_q - IW'(1);
        if (!dgt_q && !dlt_q) begin
          dgt_d = cur_gt;
          dlt_d = cur_lt;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0; b_q <= '0; mode_q <= '0; idx_q <= '0;
      dgt_q <= 1'b0; dlt_q <= 1'b0;
      gt_q <= 1'b0; eq_q <= 1'b0; lt_q <= 1'b0; inv_q <= 1'b0; res_q <= 1'b0;
    end else begin
      a_q <= a_d; b_q <= b_d; mode_q <= mode_d; idx_q <= idx_d;
      dgt_q <= dgt_d; dlt_q <= dlt_d;
      gt_q <= gt_d; eq_q <= eq_d; lt_q <= lt_d; inv_q <= inv_d; res_q <= res_d;
    end
  end

  assign result  = res_q;
  assign a_gt_b  = gt_q;
  assign a_eq_b  = eq_q;
  assign a_lt_b  = lt_q;
  assign invalid = inv_q;
endmodule

// File: tb/tb_bcd_serial_comparator.sv
module tb_bcd_serial_comparator;
  localparam int DIGITS = 4;
  localparam int W = 4*DIGITS;

  typedef struct {
    int k;
    bit gt, eq, lt, inv, res;
  } exp_t;

  typedef struct {
    logic [W-1:0] a, b;
    logic [1:0]   m;
    exp_t         e1, e0;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [1:0] mode = '0;
  // index 1: early-exit instance, index 0: fixed-latency instance
  logic [1:0] busy_v, done_v, res_v, gt_v, eq_v, lt_v, inv_v;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_serial_comparator #(.DIGITS(DIGITS), .EARLY_EXIT(1)) u_ee1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .mode(mode),
    .busy(busy_v[1]), .done(done_v[1]), .result(res_v[1]), .a_gt_b(gt_v[1]),
    .a_eq_b(eq_v[1]), .a_lt_b(lt_v[1]), .invalid(inv_v[1]));

  bcd_serial_comparator #(.DIGITS(DIGITS), .EARLY_EXIT(0)) u_ee0 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .mode(mode),
    .busy(busy_v[0]), .done(done_v[0]), .result(res_v[0]), .a_gt_b(gt_v[0]),
    .a_eq_b(eq_v[0]), .a_lt_b(lt_v[0]), .invalid(inv_v[0]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: decimal values and the first distinguishing digit from the MSD.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [1:0] m, input bit ee);
    exp_t e;
    int va, vb, dx, dy;
    bit found;
    e = '{DIGITS, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    va = 0; vb = 0; found = 0;
    for (int p = 1; p <= DIGITS; p++) begin
      dx = int'(x[4*(DIGITS-p) +: 4]);
      dy = int'(y[4*(DIGITS-p) +: 4]);
      if (!found && (dx > 9 || dy > 9)) begin
        found = 1; e.k = p; e.inv = 1;
      end else if (!found && ee && dx != dy) begin
        found = 1; e.k = p; e.gt = dx > dy; e.lt = dx < dy;
      end
      va = va*10 + dx;
      vb = vb*10 + dy;
    end
    if (!found) begin
      e.gt = va > vb; e.lt = va < vb; e.eq = va == vb;
    end
    if (!e.inv) begin
      case (m)
        2'b00:   e.res = e.gt | e.eq;
        2'b01:   e.res = e.gt;
        2'b10:   e.res = e.eq;
        default: e.res = e.lt;
      endcase
    end
    return e;
  endfunction

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s/ee%0d/outs", tag, d),
          {busy_v[d], done_v[d], res_v[d], gt_v[d], eq_v[d], lt_v[d], inv_v[d]}, 0);
    end
  endtask

  // Run one compare on both instances, then check latency, flags and the single done pulse.
  task automatic check_cmp(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                           input logic [1:0] tm, input exp_t e1, input exp_t e0);
    exp_t ex[2];
    int k[2], pulses[2];
    logic [4:0] got[2];
    ex[0] = e0; ex[1] = e1;
    for (int d = 0; d < 2; d++) begin k[d] = 0; pulses[d] = 0; got[d] = '0; end
    @(negedge clk);
    a = ta; b = tb_; mode = tm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); mode = 2'($urandom);
    for (int c = 1; c <= DIGITS + 3; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        if (c == 1) chk($sformatf("%s/ee%0d/busy1", tag, d), busy_v[d], ex[d].k > 1);
        if (done_v[d]) begin
          pulses[d]++;
          if (k[d] == 0) begin
            k[d] = c;
            got[d] = {gt_v[d], eq_v[d], lt_v[d], inv_v[d], res_v[d]};
          end
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s/ee%0d/lat", tag, d), k[d], ex[d].k);
      chk($sformatf("%s/ee%0d/pulses", tag, d), pulses[d], 1);
      chk($sformatf("%s/ee%0d/gt,eq,lt,inv,res", tag, d), got[d],
          {ex[d].gt, ex[d].eq, ex[d].lt, ex[d].inv, ex[d].res});
      chk($sformatf("%s/ee%0d/held", tag, d),
          {gt_v[d], eq_v[d], lt_v[d], inv_v[d], res_v[d]},
          {ex[d].gt, ex[d].eq, ex[d].lt, ex[d].inv, ex[d].res});
    end
  endtask

  initial begin
    vec_t tbl[12];
    logic [W-1:0] ra, rb;
    logic [1:0] rm;
    int r;

    tbl[0]  = '{16'h1234, 16'h1234, 2'b00, '{4,0,1,0,0,1}, '{4,0,1,0,0,1}};
    tbl[1]  = '{16'h5000, 16'h4999, 2'b01, '{1,1,0,0,0,1}, '{4,1,0,0,0,1}};
    tbl[2]  = '{16'h0999, 16'h1000, 2'b11, '{1,0,0,1,0,1}, '{4,0,0,1,0,1}};
    tbl[3]  = '{16'h12A4, 16'h1294, 2'b00, '{3,0,0,0,1,0}, '{3,0,0,0,1,0}};
    tbl[4]  = '{16'h12A4, 16'h1294, 2'b01, '{3,0,0,0,1,0}, '{3,0,0,0,1,0}};
    tbl[5]  = '{16'h0000, 16'h0000, 2'b10, '{4,0,1,0,0,1}, '{4,0,1,0,0,1}};
    tbl[6]  = '{16'h9999, 16'h0000, 2'b00, '{1,1,0,0,0,1}, '{4,1,0,0,0,1}};
    tbl[7]  = '{16'h5A00, 16'h4000, 2'b01, '{1,1,0,0,0,1}, '{2,0,0,0,1,0}};
    tbl[8]  = '{16'h123F, 16'h1230, 2'b11, '{4,0,0,0,1,0}, '{4,0,0,0,1,0}};
    tbl[9]  = '{16'h1230, 16'h1239, 2'b11, '{4,0,0,1,0,1}, '{4,0,0,1,0,1}};
    tbl[10] = '{16'h0010, 16'h0009, 2'b10, '{3,1,0,0,0,0}, '{4,1,0,0,0,0}};
    tbl[11] = '{16'hF000, 16'h0000, 2'b00, '{1,0,0,0,1,0}, '{1,0,0,0,1,0}};

    // Reset state
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      check_cmp($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].e1, tbl[i].e0);

    // Start held high: the second compare is accepted on the done cycle.
    @(negedge clk);
    a = 16'h0001; b = 16'h0002; mode = 2'b11; start = 1'b1;
    @(posedge clk); #1;                         // E0
    for (int c = 1; c <= 4; c++) begin @(posedge clk); #1; end
    for (int d = 0; d < 2; d++)
      chk($sformatf("b2b1/ee%0d/done,lt,res", d), {done_v[d], lt_v[d], res_v[d]}, 3'b111);
    a = 16'h0003; b = 16'h0002;
    @(posedge clk); #1;                         // re-accept edge
    start = 1'b0;
    for (int d = 0; d < 2; d++)
      chk($sformatf("b2b_acc/ee%0d/done,busy,lt", d), {done_v[d], busy_v[d], lt_v[d]}, 3'b010);
    for (int c = 1; c <= 4; c++) begin @(posedge clk); #1; end
    for (int d = 0; d < 2; d++)
      chk($sformatf("b2b2/ee%0d/done,gt,res", d), {done_v[d], gt_v[d], res_v[d]}, 3'b110);
    @(posedge clk); #1;

    // Start while busy is ignored, and new operands do not disturb the scan.
    @(negedge clk);
    a = 16'h0000; b = 16'h0000; mode = 2'b10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    a = 16'h9999; mode = 2'b01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("busy_start/ee%0d/done,eq,res", d), {done_v[d], eq_v[d], res_v[d]}, 3'b111);
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("busy_start/ee%0d/idle", d), {busy_v[d], done_v[d]}, 2'b00);

    // Reset mid-scan
    @(negedge clk);
    a = 16'h1234; b = 16'h1235; mode = 2'b11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) chk($sformatf("midreset%0d/ee%0d/done", c, d), done_v[d], 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_cmp("after_reset", 16'h1234, 16'h1235, 2'b11,
              '{4,0,0,1,0,1}, '{4,0,0,1,0,1});

    // Randomized compares against the model
    for (int i = 0; i < 150; i++) begin
      for (int g = 0; g < DIGITS; g++) begin
        r = $urandom_range(0, 99);
        ra[4*g +: 4] = (r < 8) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        r = $urandom_range(0, 99);
        if (r < 60) rb[4*g +: 4] = ra[4*g +: 4];
        else if (r < 66) rb[4*g +: 4] = 4'($urandom_range(10, 15));
        else rb[4*g +: 4] = 4'($urandom_range(0, 9));
      end
      rm = 2'($urandom);
      check_cmp($sformatf("rnd%0d", i), ra, rb, rm, model(ra, rb, rm, 1'b1), model(ra, rb, rm, 1'b0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
